// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit arbiter.
// Holds the arbiter state enum, byte width and newd hold-time function.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        ACK
    } arb_state_t;

    // newd must outlast one baud-clock period so the slow side samples it
    function automatic int hold_cycles(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate + 4;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester bus plus transmitter handshake.
// slave = arbiter view, master = client/transmitter view.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*BYTE_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic [IDW-1:0]            grant_id;
    logic                      busy;
    logic                      tx_newd;
    logic [BYTE_W-1:0]         tx_data;
    logic                      tx_done;
    logic                      timeout_err;

    modport slave (
        input  req, req_data, tx_done,
        output ack, grant_id, busy,
        output tx_newd, tx_data, timeout_err
    );

    modport master (
        output req, req_data, tx_done,
        input  ack, grant_id, busy,
        input  tx_newd, tx_data, timeout_err
    );

endinterface

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: combinational round-robin winner select.
// Returns the first set req at or above ptr, wrapping past NUM_REQ-1.
module uart_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic               valid,
    output logic [IDW-1:0]     winner
);

    always_comb begin
        int j;
        valid  = 1'b0;
        winner = '0;
        j      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!valid && req[IDW'(j)]) begin
                valid  = 1'b1;
                winner = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter.
// Optional grant-to-done watchdog enabled by UART_TX_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int CLK_FREQ       = 1000000,
    parameter int BAUD_RATE      = 9600,
    parameter int TIMEOUT_CYCLES = 4000
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);

    localparam int HOLD_CYCLES = hold_cycles(CLK_FREQ, BAUD_RATE);
    localparam int IDW         = $clog2(NUM_REQ);
    localparam int HW          = $clog2(HOLD_CYCLES + 1);

    arb_state_t         state_q, state_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               done_seen_q, done_seen_d;
    logic               tx_done_q;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [IDW-1:0]     pick_idx;
    logic               pick_valid;
    logic [BYTE_W-1:0]  data_q, data_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               newd_q, newd_d;
    logic               done_rise, done_any;
    logic [BYTE_W-1:0]  req_bytes [NUM_REQ];

`ifdef UART_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_q, to_d;
    logic          to_err_q, to_err_d;
`endif

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] g);
        if (int'(g) == NUM_REQ - 1) return '0;
        return g + IDW'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            req_bytes[i] = bus.req_data[i*BYTE_W +: BYTE_W];
    end

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    assign done_rise = bus.tx_done & ~tx_done_q;
    assign done_any  = done_seen_q | done_rise;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        done_seen_d = done_seen_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        data_d      = data_q;
        ack_d       = '0;
        newd_d      = newd_q;
`ifdef UART_TX_TIMEOUT_EN
        to_d        = to_q;
        to_err_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                hold_d      = '0;
                done_seen_d = 1'b0;
                newd_d      = 1'b0;
`ifdef UART_TX_TIMEOUT_EN
                to_d        = '0;
`endif
                if (pick_valid) begin
                    grant_d = pick_idx;
                    data_d  = req_bytes[pick_idx];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                done_seen_d = done_any;
                if (hold_q == HW'(HOLD_CYCLES)) begin
                    newd_d  = 1'b0;
                    state_d = done_any ? ACK : WAIT;
                end else begin
                    newd_d  = 1'b1;
                    hold_d  = hold_q + HW'(1);
                end
            end
            WAIT: begin
                done_seen_d = done_any;
                if (done_any) state_d = ACK;
            end
            ACK: begin
                ptr_d   = next_ptr(grant_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef UART_TX_TIMEOUT_EN
        // abandon the byte and skip its owner so others are not starved
        if (state_q == LOAD || state_q == WAIT) begin
            to_d = to_q + TW'(1);
            if (!done_any && to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d  = IDLE;
                newd_d   = 1'b0;
                to_err_d = 1'b1;
                ptr_d    = next_ptr(grant_q);
            end
        end
`endif
        if (state_d == ACK) ack_d[grant_q] = 1'b1;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            done_seen_q <= 1'b0;
            tx_done_q   <= 1'b0;
            ptr_q       <= '0;
            grant_q     <= '0;
            data_q      <= '0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
            newd_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            done_seen_q <= done_seen_d;
            tx_done_q   <= bus.tx_done;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            data_q      <= data_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            newd_q      <= newd_d;
        end
    end

`ifdef UART_TX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            to_q     <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_q     <= to_d;
            to_err_q <= to_err_d;
        end
    end

    assign bus.timeout_err = to_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.ack      = ack_q;
    assign bus.grant_id = grant_q;
    assign bus.busy     = busy_q;
    assign bus.tx_newd  = newd_q;
    assign bus.tx_data  = data_q;

endmodule
